lim_counter: RTL and testbench

- Parametrised, cascadable, modulo-(LIMIT+1) up/down counter; the sequential successor of the team's limited incrementor.
- Counts 0..LIMIT with wrap-around and a combinational carry/borrow out.
- Chaining lets counters build multi-digit decimal or time counters (e.g. seconds 00..59, minutes) for the lab display datapath.
- Adds synchronous clear, parallel load with range clamping, and a sticky load-error flag.

---
 rtl/lim_counter.sv | 57 +++++
 tb/tb_lim_counter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/lim_counter.sv
// Cascadable modulo-(LIMIT+1) up/down counter with clear, clamped load and sticky load-error flag.
// count updates one edge after inputs are sampled; co is combinational (zero latency); no backpressure.
module lim_counter #(
    parameter int WIDTH = 4,
    parameter int LIMIT = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up_dn,
    output logic [WIDTH-1:0] count,
    output logic             co,
    output logic             load_err
);

    if (LIMIT < 1 || LIMIT > (2 ** WIDTH) - 1) begin : g_bad_limit
        $error("lim_counter: LIMIT out of range for WIDTH");
    end

    localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

    logic at_top;
    logic at_bot;

    assign at_top = (count == LIM);
    assign at_bot = (count == '0);

    // Gated by rst_n so a downstream stage never sees a wrap while this one is held in reset.
    assign co = rst_n & en & ~clear & ~load & ((up_dn & at_top) | (~up_dn & at_bot));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            load_err <= 1'b0;
        end else if (clear) begin
            count    <= '0;
            load_err <= 1'b0;
        end else if (load) begin
            if (load_val > LIM) begin
                count    <= LIM;
                load_err <= 1'b1;
            end else begin
                count    <= load_val;
            end
        end else if (en) begin
            if (up_dn) begin
                count <= at_top ? '0 : count + 1'b1;
            end else begin
                count <= at_bot ? LIM : count - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lim_counter.sv
// Directed self-checking bench for lim_counter: single stage (LIMIT=9) plus a 00..59 cascade.
module tb_lim_counter;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       load;
    logic [3:0] load_val;
    logic       en;
    logic       up_dn;
    logic [3:0] count;
    logic       co;
    logic       load_err;

    logic       c_clear;
    logic       c_en;
    logic [3:0] ones_count;
    logic       ones_co;
    logic       ones_err;
    logic [3:0] tens_count;
    logic       tens_co;
    logic       tens_err;

    int errors = 0;
    int checks = 0;

    lim_counter #(.WIDTH(4), .LIMIT(9)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .load(load), .load_val(load_val),
        .en(en), .up_dn(up_dn), .count(count), .co(co), .load_err(load_err)
    );

    lim_counter #(.WIDTH(4), .LIMIT(9)) u_ones (
        .clk(clk), .rst_n(rst_n), .clear(c_clear), .load(1'b0), .load_val(4'd0),
        .en(c_en), .up_dn(1'b1), .count(ones_count), .co(ones_co), .load_err(ones_err)
    );

    lim_counter #(.WIDTH(4), .LIMIT(5)) u_tens (
        .clk(clk), .rst_n(rst_n), .clear(c_clear), .load(1'b0), .load_val(4'd0),
        .en(ones_co), .up_dn(1'b1), .count(tens_count), .co(tens_co), .load_err(tens_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int up_exp [12]  = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        int up_co  [12]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        int dn_exp [4]   = '{1, 0, 9, 8};
        int dn_co  [4]   = '{0, 0, 1, 0};
        int n;

        rst_n    = 1'b0;
        clear    = 1'b0;
        load     = 1'b0;
        load_val = 4'd0;
        en       = 1'b1;
        up_dn    = 1'b1;
        c_clear  = 1'b0;
        c_en     = 1'b0;

        // Reset state with en asserted
        tick();
        tick();
        check("reset_count", 32'(count), 0);
        check("reset_co", 32'(co), 0);
        check("reset_err", 32'(load_err), 0);
        check("reset_cascade", 32'({tens_count, ones_count}), 0);
        #3 rst_n = 1'b1;

        // Up-count through wrap
        for (int i = 0; i < 12; i++) begin
            #1;
            check($sformatf("up_co[%0d]", i), 32'(co), 32'(up_co[i]));
            tick();
            check($sformatf("up_count[%0d]", i), 32'(count), 32'(up_exp[i]));
        end

        // Down-count through borrow
        up_dn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("dn_co[%0d]", i), 32'(co), 32'(dn_co[i]));
            tick();
            check($sformatf("dn_count[%0d]", i), 32'(count), 32'(dn_exp[i]));
        end

        // Load and clamp
        en = 1'b0;
        up_dn = 1'b1;
        load = 1'b1;
        load_val = 4'd6;
        tick();
        check("load6_count", 32'(count), 6);
        check("load6_err", 32'(load_err), 0);
        load_val = 4'd13;
        tick();
        check("load13_count", 32'(count), 9);
        check("load13_err", 32'(load_err), 1);
        load_val = 4'd3;
        tick();
        check("load3_count", 32'(count), 3);
        check("load3_err_sticky", 32'(load_err), 1);
        load = 1'b0;
        tick();
        check("hold_count", 32'(count), 3);
        clear = 1'b1;
        tick();
        check("clear_count", 32'(count), 0);
        check("clear_err", 32'(load_err), 0);

        // Priority: clear beats load and en
        load = 1'b1;
        en = 1'b1;
        load_val = 4'd5;
        #1;
        check("prio_clear_co", 32'(co), 0);
        tick();
        check("prio_clear_count", 32'(count), 0);

        // Priority: load beats en at the wrap point
        clear = 1'b0;
        en = 1'b0;
        load_val = 4'd9;
        tick();
        check("load9_count", 32'(count), 9);
        en = 1'b1;
        load_val = 4'd4;
        #1;
        check("prio_load_co", 32'(co), 0);
        tick();
        check("prio_load_count", 32'(count), 4);
        check("prio_load_err", 32'(load_err), 0);

        // Cascade 00..59 then 00
        load = 1'b0;
        en = 1'b0;
        c_en = 1'b1;
        n = 0;
        for (int i = 0; i < 60; i++) begin
            #1;
            check($sformatf("casc_ones_co[%0d]", n), 32'(ones_co), 32'((n % 10) == 9));
            check($sformatf("casc_tens_co[%0d]", n), 32'(tens_co), 32'(n == 59));
            tick();
            n = (n + 1) % 60;
            check($sformatf("casc_val[%0d]", n), 32'(tens_count) * 10 + 32'(ones_count), 32'(n));
        end
        c_en = 1'b0;

        // Async reset mid-operation, with a sticky error pending
        load = 1'b1;
        load_val = 4'd13;
        tick();
        load_val = 4'd7;
        tick();
        check("pre_rst_count", 32'(count), 7);
        check("pre_rst_err", 32'(load_err), 1);
        load = 1'b0;
        en = 1'b1;
        up_dn = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_count", 32'(count), 0);
        check("async_rst_co", 32'(co), 0);
        check("async_rst_err", 32'(load_err), 0);
        up_dn = 1'b0;
        #1;
        check("rst_co_gated_down", 32'(co), 0);
        up_dn = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_count", 32'(count), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
